// File: rtl/quad_emu_pkg.sv
// Shared types and quadrature sequencing helpers for the encoder emulator.
// Forward order of {a,b} is 00 -> 10 -> 11 -> 01 -> 00; reverse walks it backwards.
package quad_emu_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } fsm_state_t;

    localparam int MIN_PERIOD_DEFAULT = 2;

    function automatic logic [1:0] next_forward(input logic [1:0] ab);
        logic [1:0] result;
        result = 2'b00;
        case (ab)
            2'b00:   result = 2'b10;
            2'b10:   result = 2'b11;
            2'b11:   result = 2'b01;
            default: result = 2'b00;
        endcase
        return result;
    endfunction

    function automatic logic [1:0] next_reverse(input logic [1:0] ab);
        logic [1:0] result;
        result = 2'b00;
        case (ab)
            2'b00:   result = 2'b01;
            2'b01:   result = 2'b11;
            2'b11:   result = 2'b10;
            default: result = 2'b00;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/edge_rate_timer.sv
// Period down-counter: fires when it reaches 1 while running and reloads the
// clamped period sampled in that same cycle, so period changes apply at reload.
module edge_rate_timer #(
    parameter int PERIOD_WIDTH = 16,
    parameter int MIN_PERIOD   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    clear,
    input  logic                    run,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    fire
);

    logic [PERIOD_WIDTH-1:0] count;
    logic [PERIOD_WIDTH-1:0] period_clamped;

    assign period_clamped = (period != '0 && period < PERIOD_WIDTH'(MIN_PERIOD))
                            ? PERIOD_WIDTH'(MIN_PERIOD) : period;

    assign fire = run && (count == PERIOD_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= period_clamped;
        end else if (run) begin
            count <= fire ? period_clamped : count - PERIOD_WIDTH'(1);
        end
    end

endmodule

// File: rtl/quadrature_encoder_emulator.sv
// Quadrature A/B/index generator driven by a commanded edge period and direction.
// Holds the run/idle FSM, channel state, signed position and per-revolution count.
module quadrature_encoder_emulator
    import quad_emu_pkg::*;
#(
    parameter int COUNTER_WIDTH  = 32,
    parameter int PERIOD_WIDTH   = 16,
    parameter int COUNTS_PER_REV = 4680,
    parameter int MIN_PERIOD     = MIN_PERIOD_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     direction,
    input  logic [PERIOD_WIDTH-1:0]  tick_period,
    input  logic                     step_req,
    input  logic                     load_position,
    input  logic [COUNTER_WIDTH-1:0] load_value,
    output logic                     encoder_a,
    output logic                     encoder_b,
    output logic                     state_change,
    output logic [COUNTER_WIDTH-1:0] position,
    output logic                     index,
    output logic                     busy
);

    localparam int REV_WIDTH = $clog2(COUNTS_PER_REV);

    fsm_state_t           state, next_state;
    logic                 go;
    logic                 timer_load, timer_clear, timer_run, timer_fire;
    logic                 step_edge, do_edge;
    logic [1:0]           ab, ab_next;
    logic [REV_WIDTH-1:0] rev_count, rev_next;
    logic [COUNTER_WIDTH-1:0] step_delta;

    edge_rate_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH),
        .MIN_PERIOD  (MIN_PERIOD)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .clear (timer_clear),
        .run   (timer_run),
        .period(tick_period),
        .fire  (timer_fire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_clear = 1'b0;
        timer_run   = 1'b0;
        step_edge   = 1'b0;
        go          = enable && (tick_period != '0);
        case (state)
            IDLE: begin
                step_edge = step_req;
                if (go) begin
                    next_state = RUN;
                    timer_load = 1'b1;
                end else begin
                    timer_clear = 1'b1;
                end
            end
            RUN: begin
                if (go) begin
                    timer_run = 1'b1;
                end else begin
                    next_state  = IDLE;
                    timer_clear = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        // A load in the same cycle swallows the edge; the timer still reloads.
        do_edge = (timer_fire || step_edge) && !load_position;
    end

    always_comb begin
        ab_next    = direction ? next_forward(ab) : next_reverse(ab);
        step_delta = direction ? COUNTER_WIDTH'(1) : {COUNTER_WIDTH{1'b1}};
        if (direction) begin
            rev_next = (rev_count == REV_WIDTH'(COUNTS_PER_REV - 1)) ? '0 : rev_count + REV_WIDTH'(1);
        end else begin
            rev_next = (rev_count == '0) ? REV_WIDTH'(COUNTS_PER_REV - 1) : rev_count - REV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ab           <= 2'b00;
            position     <= '0;
            rev_count    <= '0;
            index        <= 1'b1;
            state_change <= 1'b0;
        end else begin
            state_change <= do_edge;
            if (load_position) begin
                position  <= load_value;
                rev_count <= '0;
                index     <= (ab == 2'b00);
            end else if (do_edge) begin
                ab        <= ab_next;
                position  <= position + step_delta;
                rev_count <= rev_next;
                index     <= (rev_next == '0) && (ab_next == 2'b00);
            end
        end
    end

    assign encoder_a = ab[1];
    assign encoder_b = ab[0];
    assign busy      = (state == RUN);

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Bench for quadrature_encoder_emulator: an edge-time reference model predicts
// every output each cycle under directed and randomized stimulus.
module tb_quadrature_encoder_emulator;

    localparam int CPR = 4680;

    logic        clk = 1'b0;
    logic        reset, enable, direction, step_req, load_position;
    logic [15:0] tick_period;
    logic [31:0] load_value;
    logic        encoder_a, encoder_b, state_change, index, busy;
    logic [31:0] position;

    int total = 0;
    int bad   = 0;

    // Reference model: phase into the A/B table, absolute cycle of the next edge.
    logic [1:0]  ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int          m_cycle = 0;
    int          m_next_edge = 0;
    bit          m_running = 0;
    int          m_phase = 0;
    int          m_rev = 0;
    logic [31:0] m_pos = '0;
    bit          m_sc = 0;

    always #5 clk = ~clk;

    quadrature_encoder_emulator dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .direction    (direction),
        .tick_period  (tick_period),
        .step_req     (step_req),
        .load_position(load_position),
        .load_value   (load_value),
        .encoder_a    (encoder_a),
        .encoder_b    (encoder_b),
        .state_change (state_change),
        .position     (position),
        .index        (index),
        .busy         (busy)
    );

    function automatic int clamp_period(input int p);
        return (p > 0 && p < 2) ? 2 : p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, m_cycle);
        end
    endtask

    task automatic model_step();
        bit go, fire;
        m_cycle++;
        fire = 0;
        if (reset) begin
            m_running = 0; m_phase = 0; m_rev = 0; m_pos = '0;
        end else begin
            go = enable && (tick_period != 0);
            if (!m_running) begin
                fire = step_req;
                if (go) begin
                    m_running   = 1;
                    m_next_edge = m_cycle + clamp_period(int'(tick_period));
                end
            end else if (!go) begin
                m_running = 0;
            end else if (m_cycle == m_next_edge) begin
                fire        = 1;
                m_next_edge = m_cycle + clamp_period(int'(tick_period));
            end
            if (load_position) begin
                m_pos = load_value;
                m_rev = 0;
                fire  = 0;
            end else if (fire) begin
                if (direction) begin
                    m_phase = (m_phase + 1) % 4;
                    m_pos   = m_pos + 32'd1;
                    m_rev   = (m_rev + 1) % CPR;
                end else begin
                    m_phase = (m_phase + 3) % 4;
                    m_pos   = m_pos - 32'd1;
                    m_rev   = (m_rev + CPR - 1) % CPR;
                end
            end
        end
        m_sc = fire;
    endtask

    task automatic checkOutput();
        logic [1:0] ab;
        ab = ab_tab[m_phase];
        check("encoder_a", {31'b0, encoder_a}, {31'b0, ab[1]});
        check("encoder_b", {31'b0, encoder_b}, {31'b0, ab[0]});
        check("state_change", {31'b0, state_change}, {31'b0, m_sc});
        check("position", position, m_pos);
        check("index", {31'b0, index}, {31'b0, (m_rev == 0 && m_phase == 0)});
        check("busy", {31'b0, busy}, {31'b0, m_running});
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            model_step();
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        int rises;
        bit prev_index;
        bit found;

        reset = 1; enable = 0; direction = 1; tick_period = 0;
        step_req = 0; load_position = 0; load_value = '0;
        applyStimulus(2);
        reset = 0;
        applyStimulus(1);

        // Forward at period 10: four edges after entry brings position to 4.
        enable = 1; direction = 1; tick_period = 16'd10;
        applyStimulus(41);
        check("fwd_position", position, 32'd4);
        check("fwd_ab", {30'b0, encoder_a, encoder_b}, 32'b00);
        enable = 0;
        applyStimulus(1);

        // Reverse from reset: three edges give {a,b}=10, position -3.
        reset = 1;
        applyStimulus(1);
        reset = 0; enable = 1; direction = 0; tick_period = 16'd10;
        applyStimulus(31);
        check("rev_position", position, 32'hFFFF_FFFD);
        check("rev_ab", {30'b0, encoder_a, encoder_b}, 32'b10);
        enable = 0;
        applyStimulus(1);

        // Clamped period, then a mid-interval period change.
        enable = 1; direction = 1; tick_period = 16'd1;
        applyStimulus(12);
        tick_period = 16'd10;
        applyStimulus(5);
        tick_period = 16'd4;
        applyStimulus(3);
        direction = 0;
        applyStimulus(20);

        // Load coincident with a scheduled edge.
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (m_cycle + 1 == m_next_edge) found = 1;
            else applyStimulus(1);
        end
        total++;
        assert (found) else begin
            bad++;
            $error("FAIL coincident_wait observed=timeout expected=edge_slot");
        end
        load_position = 1; load_value = 32'h0000_1234;
        applyStimulus(1);
        check("load_sc", {31'b0, state_change}, 32'd0);
        check("load_position", position, 32'h0000_1234);
        load_position = 0;
        applyStimulus(10);

        // Revolution wrap: index rises exactly once over 4680 forward edges.
        enable = 0; reset = 1;
        applyStimulus(1);
        reset = 0; load_position = 1; load_value = 32'd4679;
        applyStimulus(1);
        load_position = 0;
        check("wrap_index_after_load", {31'b0, index}, 32'd1);
        enable = 1; direction = 1; tick_period = 16'd2;
        rises = 0;
        prev_index = index;
        for (int i = 0; i < 2 * CPR + 1; i++) begin
            applyStimulus(1);
            if (index && !prev_index) rises++;
            prev_index = index;
        end
        check("wrap_index_rises", rises, 32'd1);
        check("wrap_position", position, 32'd9359);

        // Single steps in IDLE; steps in RUN are ignored; reset during RUN.
        enable = 0;
        applyStimulus(1);
        step_req = 1; direction = 1;
        applyStimulus(1);
        step_req = 0;
        check("step_position", position, 32'd9360);
        applyStimulus(2);
        enable = 1; tick_period = 16'd5;
        applyStimulus(3);
        step_req = 1;
        applyStimulus(1);
        step_req = 0;
        applyStimulus(8);
        reset = 1;
        applyStimulus(1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        reset = 0;

        // Randomized run against the model.
        for (int i = 0; i < 2500; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) direction = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) tick_period = 16'($urandom_range(0, 6));
            step_req      = ($urandom_range(0, 7) == 0);
            load_position = ($urandom_range(0, 39) == 0);
            load_value    = $urandom;
            reset         = ($urandom_range(0, 299) == 0);
            applyStimulus(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
